// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and a UART transmitter.
// The slave side is the arbiter; the master side drives requests and the tx_busy flag.
interface uart_tx_arbiter_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_owner;
  logic [13:0] byte_count;
  logic        timeout_err;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_start, tx_data, tx_owner, byte_count, timeout_err
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_start, tx_data, tx_owner, byte_count, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from two requesters into a single UART transmitter,
// with a watchdog on the transmitter's busy response and a completed-frame counter.
module uart_tx_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               nrst,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        last_grant;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        tx_owner_q;
  logic [13:0] byte_count_q;
  logic        timeout_q;

  logic        can_accept;
  logic        sel;
  logic        rdy0;
  logic        rdy1;

  // The cycle carrying the timeout pulse is held off from accepting so the two never coincide.
  always_comb begin
    can_accept = nrst && (state == IDLE) && !bus.tx_busy && !timeout_q;
    sel        = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    rdy0       = can_accept && bus.req0_valid && !sel;
    rdy1       = can_accept && bus.req1_valid && sel;
  end

  // cnt counts cycles since tx_start, so the pulse lands BUSY_TIMEOUT cycles after it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      tx_owner_q   <= 1'b0;
      byte_count_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (rdy0 || rdy1) begin
            tx_data_q  <= rdy1 ? bus.req1_data : bus.req0_data;
            tx_owner_q <= rdy1;
            last_grant <= rdy1;
            cnt        <= '0;
            tx_start_q <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= cnt + 8'd1;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            byte_count_q <= byte_count_q + 14'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_owner    = tx_owner_q;
  assign bus.byte_count  = byte_count_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a transaction-level model
// (round-robin grant prediction, frame counting modulo 2^14) and a simple transmitter model.
module tb_uart_tx_arbiter;
  localparam int unsigned BT = 16;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.BUSY_TIMEOUT(BT)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transmitter model: busy rises the cycle after tx_start and stays up busy_len cycles.
  int   tx_mode  = 0;   // 0: responsive, 1: never raises busy
  int   busy_len = 1;
  logic mbusy    = 1'b0;
  logic ext_busy = 1'b0;
  bit   pend     = 1'b0;
  int   left     = 0;

  assign bus.tx_busy = mbusy | ext_busy;

  always begin
    @(posedge clk);
    #1;
    if (!nrst) begin
      mbusy = 1'b0;
      pend  = 1'b0;
      left  = 0;
    end else begin
      if (pend) begin
        pend  = 1'b0;
        mbusy = 1'b1;
        left  = busy_len;
      end else if (mbusy) begin
        left = left - 1;
        if (left <= 0) mbusy = 1'b0;
      end
      if (bus.tx_start && tx_mode == 0) pend = 1'b1;
    end
  end

  // Reference state: frames completed and the requester that won last.
  int exp_bc   = 0;
  bit exp_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                          input int len, input bit drop, output int waited);
    bit         exp_owner;
    logic [7:0] exp_data;
    bit         got;
    int         n;
    busy_len        = len;
    bus.req0_valid  = v0;
    bus.req1_valid  = v1;
    bus.req0_data   = d0;
    bus.req1_data   = d1;
    #1;
    exp_owner = (v0 && v1) ? ~exp_last : v1;
    exp_data  = exp_owner ? d1 : d0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 100) begin
      if (bus.req0_ready || bus.req1_ready) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    waited = n;
    chk("accept_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("grant", 32'({bus.req1_ready, bus.req0_ready}), exp_owner ? 32'd2 : 32'd1);
    chk("no_start_with_ready", 32'(bus.tx_start), 32'd0);
    @(posedge clk);
    #1;
    exp_last = exp_owner;
    if (drop) begin
      if (exp_owner) begin
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'($urandom);
      end else begin
        bus.req0_valid = 1'b0;
        bus.req0_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    chk("tx_start", 32'(bus.tx_start), 32'd1);
    chk("tx_data", 32'(bus.tx_data), 32'(exp_data));
    chk("tx_owner", 32'(bus.tx_owner), 32'(exp_owner));
    chk("ready_in_start", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    exp_bc = (exp_bc + 1) % 16384;
    n = 0;
    while (bus.byte_count !== 14'(exp_bc) && n < len + 20) begin
      @(negedge clk);
      n++;
    end
    chk("byte_count", 32'(bus.byte_count), 32'(exp_bc));
    chk("tx_data_held", 32'(bus.tx_data), 32'(exp_data));
    chk("tx_owner_held", 32'(bus.tx_owner), 32'(exp_owner));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    int bad;
    int frames;

    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'h11;
    bus.req1_data  = 8'h22;

    // Reset state, with both requesters already valid
    #2;
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_tx_owner", 32'(bus.tx_owner), 32'd0);
    chk("rst_byte_count", 32'(bus.byte_count), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;

    // Contention: first tie goes to requester 0, then alternates
    for (int i = 0; i < 4; i++) do_frame(1'b1, 1'b1, 8'h6E, 8'h61, 30, 1'b0, w);
    chk("contention_count", 32'(bus.byte_count), 32'd4);

    // Single requester with a long frame
    do_frame(1'b1, 1'b0, 8'h53, 8'h00, 1250, 1'b0, w);

    // Transmitter never answers
    tx_mode        = 1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hA5;
    #1;
    n = 0;
    while (!bus.req0_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_accept", 32'(bus.req0_ready), 32'd1);
    exp_last = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("to_start", 32'(bus.tx_start), 32'd1);
    n = 0;
    while (!bus.timeout_err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 32'(n), 32'(BT));
    chk("timeout_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    chk("timeout_no_start", 32'(bus.tx_start), 32'd0);
    chk("timeout_count", 32'(bus.byte_count), 32'(exp_bc));
    @(negedge clk);
    chk("timeout_one_cycle", 32'(bus.timeout_err), 32'd0);
    chk("idle_after_timeout", 32'(bus.req0_ready), 32'd1);
    bus.req0_valid = 1'b0;
    tx_mode        = 0;

    // External busy holds the arbiter in IDLE
    @(posedge clk);
    #1;
    ext_busy       = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ext_busy_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("ext_busy_no_start", 32'(bus.tx_start), 32'd0);
    end
    @(posedge clk);
    #1;
    ext_busy = 1'b0;
    do_frame(1'b1, 1'b0, 8'h3C, 8'h00, 5, 1'b0, w);
    chk("ext_busy_first_cycle", 32'(w), 32'd0);

    // Randomized traffic, sometimes withdrawing valid right after accept
    for (int i = 0; i < 40; i++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      do_frame(pat[0], pat[1], 8'($urandom), 8'($urandom), int'($urandom_range(1, 12)),
               1'($urandom_range(0, 1)), w);
    end

    // Reset during WAIT_DONE
    busy_len       = 60;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hC7;
    #1;
    n = 0;
    while (!bus.req1_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_accept", 32'(bus.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    repeat (6) @(negedge clk);
    chk("mid_busy", 32'(bus.tx_busy), 32'd1);
    bus.req0_valid = 1'b1;
    #2;
    nrst = 1'b0;
    #1;
    chk("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("mid_rst_tx_owner", 32'(bus.tx_owner), 32'd0);
    chk("mid_rst_byte_count", 32'(bus.byte_count), 32'd0);
    chk("mid_rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("mid_rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    exp_bc   = 0;
    exp_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    do_frame(1'b0, 1'b1, 8'h4D, 8'h9B, 5, 1'b0, w);
    do_frame(1'b1, 1'b1, 8'h12, 8'h34, 3, 1'b0, w);

    // Run the counter through its wrap with a fast transmitter
    busy_len       = 1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h7E;
    frames         = 16384 - exp_bc;
    bad            = 0;
    for (int i = 0; i < frames; i++) begin
      exp_bc = (exp_bc + 1) % 16384;
      n = 0;
      while (bus.byte_count !== 14'(exp_bc) && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        bad++;
        break;
      end
    end
    chk("wrap_progress", 32'(bad), 32'd0);
    chk("wrap_zero", 32'(bus.byte_count), 32'd0);
    chk("wrap_no_timeout", 32'(bus.timeout_err), 32'd0);
    bus.req0_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 16, sets the maximum cycles to wait for tx_busy to rise after tx_start; legal range 2..255.
REQ-002 clk  input  1  system clock (12 MHz), all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low; one clock, no other reset.
REQ-004 req0_valid  input  1  requester 0 has a byte to send.
REQ-005 req0_data  input  8  requester 0 byte; must be stable while req0_valid=1.
REQ-006 req0_ready  output  1  requester 0 byte accepted this cycle when req0_valid=1.
REQ-007 req1_valid  input  1  requester 1 has a byte to send.
REQ-008 req1_data  input  8  requester 1 byte.
REQ-009 req1_ready  output  1  requester 1 byte accepted this cycle when req1_valid=1.
REQ-010 tx_busy  input  1  busy flag from the UART transmitter; 1 while a frame is on tx.
REQ-011 tx_start  output  1  one-cycle pulse that launches a frame in the transmitter.
REQ-012 tx_data  output  8  byte presented to the transmitter; held constant from accept until return to IDLE.
REQ-013 tx_owner  output  1  index of the requester whose byte is currently in flight.
REQ-014 byte_count  output  14  count of frames completed since reset.
REQ-015 timeout_err  output  1  one-cycle pulse when the transmitter fails to assert tx_busy in time.

Function
REQ-016 The FSM SHALL have four states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-017 In IDLE with tx_busy=0, the arbiter SHALL select a requester combinationally:
  - only one valid: select that one;
  - both valid: select the one not equal to last_grant (round-robin).
REQ-018 reqN_ready SHALL be 1 only when all of the following hold: state=IDLE, tx_busy=0, reqN_valid=1, requester N selected. At most one ready SHALL be high in any cycle.
REQ-019 On an accept (valid and ready both 1), the block SHALL, at the next edge:
  - latch reqN_data into tx_data;
  - set tx_owner=N and last_grant=N;
  - clear the timeout counter;
  - go to START.
REQ-020 In START, tx_start SHALL be 1 for exactly that cycle, and the FSM SHALL go to WAIT_BUSY. Accept-to-tx_start latency is 1 cycle.
REQ-021 In WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE;
  - otherwise, increment the counter;
  - when the counter equals BUSY_TIMEOUT-1 with tx_busy=0: pulse timeout_err for one cycle, go to IDLE, leave byte_count unchanged.
REQ-022 In WAIT_DONE, when tx_busy=0 the block SHALL increment byte_count and go to IDLE. The next accept occurs no earlier than the cycle after return to IDLE.
REQ-023 byte_count SHALL wrap from 16383 to 0 without a flag.
REQ-024 IDLE with tx_busy=1 (transmitter driven elsewhere or still draining) SHALL hold both ready outputs low and remain in IDLE.
REQ-025 Deassertion of reqN_valid after accept SHALL have no effect on the frame in flight.
REQ-026 tx_start, reqN_ready and timeout_err SHALL never be asserted in the same cycle as each other.

Reset
REQ-027 While nrst=0, regardless of clk, the block SHALL force:
  - state=IDLE;
  - tx_start=0, tx_data=8'h00, tx_owner=0;
  - byte_count=0, timeout_err=0;
  - counter=0, last_grant=1 (so requester 0 wins the first tie).
REQ-028 Reset asserted mid-frame SHALL abort immediately. No byte_count increment, no timeout_err. The first accept after release follows REQ-017.
REQ-029 Ready outputs SHALL be 0 during reset.

Verification
REQ-030 Single requester: after reset, req0_valid=1, req0_data=8'h53, transmitter model raises busy 1 cycle after tx_start for 1250 cycles. Required: req0_ready pulse 1 cycle; tx_start the next cycle; tx_data=8'h53, tx_owner=0; byte_count=1 after busy falls.
REQ-031 Contention: both valid continuously, data0=8'h6E, data1=8'h61. Required:
  - grants alternate 0,1,0,1;
  - tx_data sequence 6E,61,6E,61;
  - byte_count=4 after four frames.
REQ-032 Timeout: transmitter model never raises busy, BUSY_TIMEOUT=16. Required:
  - timeout_err pulses exactly 16 cycles after tx_start;
  - FSM back in IDLE;
  - byte_count unchanged at 0.
REQ-033 Reset mid-frame: assert nrst=0 during WAIT_DONE. Required:
  - all outputs at REQ-027 values immediately (asynchronous);
  - after release, a req1-only request is granted with tx_owner=1.
REQ-034 Wrap: preload via 16384 completed frames with a short-busy transmitter model. Required: byte_count reads 0 after the 16384th frame.
REQ-035 External busy: hold tx_busy=1 while in IDLE with req0_valid=1. Required: no ready, no tx_start until busy falls; accept on the first cycle busy=0.
